bandit_egreedy: RTL and testbench

BANDIT_EGREEDY -- requirements
Module: bandit_egreedy

---
 rtl/bandit_egreedy.sv | 147 ++++++++++++++
 tb/tb_bandit_egreedy.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bandit_egreedy.sv
// Epsilon-greedy multi-armed bandit.
// After clearing, each round scans the action-value table for the argmax and
// then either exploits it or explores an LFSR-chosen action. It issues the
// action, waits for a reward, and nudges that action's value toward the
// reward by 2**-RATE_SHIFT.
module bandit_egreedy #(
  parameter int unsigned ACTION_WIDTH = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RATE_SHIFT   = 3,
  parameter int unsigned EPSILON      = 26,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reward_valid,
  input  logic [DATA_WIDTH-1:0]   reward_data,
  output logic                    reward_ready,
  output logic                    action_valid,
  output logic [ACTION_WIDTH-1:0] action_data,
  input  logic                    action_ready
);

  localparam int unsigned             Actions   = 2 ** ACTION_WIDTH;
  localparam logic [ACTION_WIDTH-1:0] LastIdx   = '1;
  localparam logic [8:0]              EpsThresh = 9'(EPSILON);

  typedef enum logic [1:0] {StClear, StSelect, StAction, StReward} state_e;

  state_e state_q, state_d;

  logic [ACTION_WIDTH-1:0] idx_q, idx_d;
  logic [ACTION_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0]   best_val_q, best_val_d;
  logic [ACTION_WIDTH-1:0] action_q, action_d;
  logic [15:0]             lfsr_q, lfsr_d;

  logic [DATA_WIDTH-1:0] action_value_table [Actions];

  logic                    idx_last;
  logic                    reward_fire;
  logic [DATA_WIDTH-1:0]   cand_val;
  logic                    cand_better;
  logic [ACTION_WIDTH-1:0] sel_idx;
  logic [DATA_WIDTH-1:0]   sel_val;
  logic                    explore;
  logic [DATA_WIDTH-1:0]   cur_val;
  logic signed [DATA_WIDTH:0] diff;
  logic signed [DATA_WIDTH:0] step_val;
  logic [DATA_WIDTH-1:0]   new_val;

  assign idx_last    = (idx_q == LastIdx);
  assign reward_fire = (state_q == StReward) && reward_valid;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: CLEAR and SELECT each sweep the whole index range once
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear:  if (idx_last)     state_d = StSelect;
      StSelect: if (idx_last)     state_d = StAction;
      StAction: if (action_ready) state_d = StReward;
      StReward: if (reward_valid) state_d = StSelect;
      default:                    state_d = StClear;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    action_valid = (state_q == StAction);
    reward_ready = (state_q == StReward);
    action_data  = action_q;
  end

  // Argmax scan, exploration decision and value update arithmetic
  always_comb begin
    cand_val    = action_value_table[idx_q];
    // Entry 0 seeds the running max; strict compare keeps the lowest index on ties
    cand_better = (idx_q == '0) || (cand_val > best_val_q);
    sel_idx     = cand_better ? idx_q : best_idx_q;
    sel_val     = cand_better ? cand_val : best_val_q;
    explore     = ({1'b0, lfsr_q[7:0]} < EpsThresh);

    cur_val  = action_value_table[action_q];
    diff     = $signed({1'b0, reward_data}) - $signed({1'b0, cur_val});
    step_val = diff >>> RATE_SHIFT;
    // Result always lies between old value and reward, so truncation is safe
    new_val  = DATA_WIDTH'({1'b0, cur_val} + step_val);

    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    action_d   = action_q;

    unique case (state_q)
      StClear: begin
        idx_d = idx_q + ACTION_WIDTH'(1);
      end
      StSelect: begin
        idx_d      = idx_q + ACTION_WIDTH'(1);
        best_idx_d = sel_idx;
        best_val_d = sel_val;
        if (idx_last) begin
          action_d = explore ? lfsr_q[15 -: ACTION_WIDTH] : sel_idx;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the index wraps to 0 at the end of each sweep
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      action_q   <= '0;
      lfsr_q     <= SEED;
    end else begin
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      action_q   <= action_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Table writes: sequential clear, then reward updates; reset blocks both
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == StClear) begin
        action_value_table[idx_q] <= '0;
      end else if (reward_fire) begin
        action_value_table[action_q] <= new_val;
      end
    end
  end

endmodule

// File: tb/tb_bandit_egreedy.sv
// Bench for bandit_egreedy: a greedy instance checked against a value-table
// model and an always-exploring instance checked against an LFSR model.
module tb_bandit_egreedy;

  localparam int unsigned AW   = 2;
  localparam int unsigned DW   = 8;
  localparam int unsigned RS   = 2;
  localparam int unsigned NACT = 2 ** AW;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clock;
  logic          reset;
  logic          rv0, rr0, av0, ar0;
  logic [DW-1:0] rd0;
  logic [AW-1:0] ad0;
  logic          rv1, rr1, av1, ar1;
  logic [DW-1:0] rd1;
  logic [AW-1:0] ad1;

  int errors = 0;
  int checks = 0;
  int q_m [NACT];

  logic [15:0] lfsr_m, lfsr_prev;

  bandit_egreedy #(
    .ACTION_WIDTH(AW), .DATA_WIDTH(DW), .RATE_SHIFT(RS), .EPSILON(0), .SEED(SEED)
  ) dut0 (
    .clock(clock), .reset(reset),
    .reward_valid(rv0), .reward_data(rd0), .reward_ready(rr0),
    .action_valid(av0), .action_data(ad0), .action_ready(ar0)
  );

  bandit_egreedy #(
    .ACTION_WIDTH(AW), .DATA_WIDTH(DW), .RATE_SHIFT(RS), .EPSILON(256), .SEED(SEED)
  ) dut1 (
    .clock(clock), .reset(reset),
    .reward_valid(rv1), .reward_data(rd1), .reward_ready(rr1),
    .action_valid(av1), .action_data(ad1), .action_ready(ar1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // LFSR reference: lfsr_prev holds the value in the cycle before the latest edge
  always @(posedge clock) begin
    lfsr_prev <= lfsr_m;
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int model_argmax();
    int best = 0;
    for (int i = 1; i < NACT; i++) if (q_m[i] > q_m[best]) best = i;
    return best;
  endfunction

  // Q + floor((r - Q) / 2**RS)
  function automatic int model_update(input int q, input int r);
    int d = r - q;
    int div = 1 << RS;
    if (d >= 0) return q + d / div;
    return q - ((-d + div - 1) / div);
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (av0 !== 1'b1 && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < NACT; i++) q_m[i] = 0;
    wait_valid(n);
    checks++;
    if (n !== 2 * NACT) begin
      errors++;
      $display("FAIL first_action_latency: got %0d expected %0d", n, 2 * NACT);
    end
  endtask

  // One full action/reward round on dut0, checked against the model
  task automatic run_txn(input int reward, input int ready_delay, input int reward_delay);
    int n;
    int a;
    logic [AW-1:0] held;
    a = model_argmax();
    wait_valid(n);
    checks++;
    if (av0 !== 1'b1 || int'(ad0) !== a) begin
      errors++;
      $display("FAIL action_choice: valid=%0b data=%0d expected data %0d", av0, ad0, a);
    end
    held = ad0;
    for (int i = 0; i < ready_delay; i++) begin
      step();
      checks++;
      if (av0 !== 1'b1 || ad0 !== held || rr0 !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: valid=%0b data=%0d rready=%0b expected 1 %0d 0",
                 av0, ad0, rr0, held);
      end
    end
    ar0 = 1'b1;
    step();
    ar0 = 1'b0;
    checks++;
    if (av0 !== 1'b0 || rr0 !== 1'b1) begin
      errors++;
      $display("FAIL enter_reward: valid=%0b rready=%0b expected 0 1", av0, rr0);
    end
    for (int i = 0; i < reward_delay; i++) begin
      rd0 = DW'($urandom);
      step();
    end
    rv0 = 1'b1;
    rd0 = DW'(reward);
    step();
    rv0 = 1'b0;
    rd0 = DW'($urandom);
    q_m[a] = model_update(q_m[a], reward);
    checks++;
    if (int'(dut0.action_value_table[a]) !== q_m[a]) begin
      errors++;
      $display("FAIL q_update: got %0d expected %0d (action %0d reward %0d)",
               dut0.action_value_table[a], q_m[a], a, reward);
    end
    wait_valid(n);
    checks++;
    if (n !== NACT) begin
      errors++;
      $display("FAIL reward_to_action_latency: got %0d expected %0d", n, NACT);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (av0 !== 1'b0 || rr0 !== 1'b0 || ad0 !== '0 || av1 !== 1'b0 || rr1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: av=%0b rr=%0b ad=%0d av1=%0b rr1=%0b expected all 0",
                 av0, rr0, ad0, av1, rr1);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < NACT; i++) q_m[i] = 0;
    for (int i = 1; i <= 2 * NACT; i++) begin
      step();
      checks++;
      if (i < 2 * NACT) begin
        if (av0 !== 1'b0 || rr0 !== 1'b0) begin
          errors++;
          $display("FAIL post_release_idle: cycle %0d av=%0b rr=%0b expected 0 0", i, av0, rr0);
        end
      end else if (av0 !== 1'b1 || ad0 !== '0) begin
        errors++;
        $display("FAIL first_action: av=%0b ad=%0d expected 1 0", av0, ad0);
      end
    end
  endtask

  task automatic test_backpressure();
    run_txn(7, 10, 2);
  endtask

  task automatic test_update();
    int exp_q [3] = '{50, 40, 30};
    int rew [3]   = '{200, 10, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_txn(rew[i], 0, 0);
      checks++;
      if (int'(dut0.action_value_table[0]) !== exp_q[i]) begin
        errors++;
        $display("FAIL update_seq: got %0d expected %0d", dut0.action_value_table[0], exp_q[i]);
      end
    end
  endtask

  task automatic test_floor();
    int exp_q [3] = '{1, 0, 0};
    int rew [3]   = '{4, 0, 3};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_txn(rew[i], 1, 1);
      checks++;
      if (int'(dut0.action_value_table[0]) !== exp_q[i]) begin
        errors++;
        $display("FAIL floor_round: got %0d expected %0d", dut0.action_value_table[0], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    run_txn(200, 0, 0);
    reset = 1'b1;
    step();
    checks++;
    if (av0 !== 1'b0 || rr0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: av=%0b rr=%0b expected 0 0", av0, rr0);
    end
    reset = 1'b0;
    for (int i = 0; i < NACT; i++) q_m[i] = 0;
    wait_valid(n);
    checks++;
    if (n !== 2 * NACT) begin
      errors++;
      $display("FAIL mid_reset_latency: got %0d expected %0d", n, 2 * NACT);
    end
    run_txn(0, 0, 0);
    checks++;
    if (int'(dut0.action_value_table[0]) !== 0) begin
      errors++;
      $display("FAIL mid_reset_reclear: got %0d expected 0", dut0.action_value_table[0]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_explore();
    int seen = 0;
    int cyc = 0;
    logic [AW-1:0] want;
    while (seen < 12 && cyc < 600) begin
      rd1 = DW'($urandom);
      step();
      cyc++;
      if (av1 === 1'b1 && rr1 === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL handshake_exclusive: av1=1 rr1=1 expected not both");
      end
      if (av1 === 1'b1) begin
        want = lfsr_prev[15 -: AW];
        seen++;
        checks++;
        if (ad1 !== want) begin
          errors++;
          $display("FAIL explore_action: got %0d expected %0d", ad1, want);
        end
      end
    end
    checks++;
    if (seen < 12) begin
      errors++;
      $display("FAIL explore_timeout: got %0d actions expected 12", seen);
    end
  endtask

  initial begin
    reset = 1'b1;
    rv0 = 1'b0; rd0 = '0; ar0 = 1'b0;
    rv1 = 1'b1; rd1 = '0; ar1 = 1'b1;
    test_reset();
    test_backpressure();
    test_update();
    test_floor();
    test_reset_mid();
    test_random();
    test_explore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
